intr_src_cond: RTL and testbench

Interrupt source conditioner sitting directly upstream of the priority interrupt controller. It synchronises raw peripheral interrupt lines and applies per-source enable, polarity and level/edge mode. Edge events are latched as pending until the controller reports them serviced. Its `intr_active_o` vector drives the controller's `intr_active_i`, and it consumes the controller's `intrt_to_be_serviced_o` / `intrt_serviced_i` to retire latched edges. Configuration uses the same APB-style register port as the controller.

---
 rtl/intr_src_cond.sv | 129 ++++++++++++
 tb/tb_intr_src_cond.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_src_cond.sv
// Interrupt source conditioner: synchronises raw interrupt lines and applies per-source
// enable, polarity and level/edge mode before the priority interrupt controller.
module intr_src_cond #(
    parameter int NUM_PHES    = 16,
    parameter int WIDTH       = $clog2(NUM_PHES),
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  pwrite_i,
    input  logic [NUM_PHES-1:0]   pwdata_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    output logic                  pready_o,
    output logic                  perror_o,
    output logic [NUM_PHES-1:0]   prdata_o,
    input  logic [NUM_PHES-1:0]   irq_i,
    output logic [NUM_PHES-1:0]   intr_active_o,
    input  logic [WIDTH-1:0]      intrt_to_be_serviced_i,
    input  logic                  intrt_serviced_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MODE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_POLARITY = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PENDING  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RAW      = ADDR_WIDTH'(4);

    logic [NUM_PHES-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PHES-1:0] enable_q;
    logic [NUM_PHES-1:0] mode_q;
    logic [NUM_PHES-1:0] polarity_q;
    logic [NUM_PHES-1:0] prev_q;
    logic [NUM_PHES-1:0] pending_q;
    logic [NUM_PHES-1:0] pending_d;
    logic [NUM_PHES-1:0] lvl;
    logic [NUM_PHES-1:0] svc_clr;
    logic [NUM_PHES-1:0] clr;
    logic [NUM_PHES-1:0] rd_mux;

    logic access;
    logic wr_ok;
    logic wr_enable;
    logic wr_mode;
    logic wr_polarity;
    logic wr_pending;

    assign access      = psel_i & penable_i;
    // RAW and the unmapped addresses reject writes, so only 0..3 are writable.
    assign wr_ok       = access & pwrite_i & (paddr_i <= ADDR_PENDING);
    assign wr_enable   = wr_ok & (paddr_i == ADDR_ENABLE);
    assign wr_mode     = wr_ok & (paddr_i == ADDR_MODE);
    assign wr_polarity = wr_ok & (paddr_i == ADDR_POLARITY);
    assign wr_pending  = wr_ok & (paddr_i == ADDR_PENDING);

    assign lvl = sync_q[SYNC_STAGES-1] ^ polarity_q;

    // Comparing against every legal index naturally ignores out-of-range service indices.
    always_comb begin
        svc_clr = '0;
        for (int i = 0; i < NUM_PHES; i++) begin
            svc_clr[i] = intrt_serviced_i && (intrt_to_be_serviced_i == WIDTH'(i));
        end
    end

    assign clr = svc_clr | (wr_pending ? pwdata_i : '0);

    // Set is checked before clear so an edge coinciding with a service is never lost.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_PHES; i++) begin
            if (!enable_q[i] || (wr_enable && !pwdata_i[i])) begin
                pending_d[i] = 1'b0;
            end else if (wr_mode && pwdata_i[i] && !mode_q[i]) begin
                pending_d[i] = 1'b0;
            end else if (!mode_q[i]) begin
                pending_d[i] = lvl[i];
            end else if (lvl[i] && !prev_q[i]) begin
                pending_d[i] = 1'b1;
            end else if (clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            enable_q   <= '0;
            mode_q     <= '0;
            polarity_q <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q    <= lvl;
            pending_q <= pending_d;
            if (wr_enable)   enable_q   <= pwdata_i;
            if (wr_mode)     mode_q     <= pwdata_i;
            if (wr_polarity) polarity_q <= pwdata_i;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (paddr_i)
            ADDR_ENABLE:   rd_mux = enable_q;
            ADDR_MODE:     rd_mux = mode_q;
            ADDR_POLARITY: rd_mux = polarity_q;
            ADDR_PENDING:  rd_mux = pending_q;
            ADDR_RAW:      rd_mux = sync_q[SYNC_STAGES-1];
            default:       rd_mux = '0;
        endcase
    end

    assign pready_o      = prst_i & access;
    assign perror_o      = prst_i & access &
                           (pwrite_i ? (paddr_i > ADDR_PENDING) : (paddr_i > ADDR_RAW));
    assign prdata_o      = (prst_i && access && !pwrite_i) ? rd_mux : '0;
    assign intr_active_o = prst_i ? pending_q : '0;

endmodule

// File: tb/tb_intr_src_cond.sv
// Self-checking bench for intr_src_cond: APB driver tasks, expected-value queue and summary.
module tb_intr_src_cond;

    localparam logic [2:0] A_ENABLE   = 3'd0;
    localparam logic [2:0] A_MODE     = 3'd1;
    localparam logic [2:0] A_POLARITY = 3'd2;
    localparam logic [2:0] A_PENDING  = 3'd3;
    localparam logic [2:0] A_RAW      = 3'd4;

    logic        pclk_i;
    logic        prst_i;
    logic [2:0]  paddr_i;
    logic        pwrite_i;
    logic [15:0] pwdata_i;
    logic        psel_i;
    logic        penable_i;
    logic        pready_o;
    logic        perror_o;
    logic [15:0] prdata_o;
    logic [15:0] irq_i;
    logic [15:0] intr_active_o;
    logic [3:0]  intrt_to_be_serviced_i;
    logic        intrt_serviced_i;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    logic [15:0] rd;
    logic        rdy;
    logic        err;

    intr_src_cond dut (
        .pclk_i                 (pclk_i),
        .prst_i                 (prst_i),
        .paddr_i                (paddr_i),
        .pwrite_i               (pwrite_i),
        .pwdata_i               (pwdata_i),
        .psel_i                 (psel_i),
        .penable_i              (penable_i),
        .pready_o               (pready_o),
        .perror_o               (perror_o),
        .prdata_o               (prdata_o),
        .irq_i                  (irq_i),
        .intr_active_o          (intr_active_o),
        .intrt_to_be_serviced_i (intrt_to_be_serviced_i),
        .intrt_serviced_i       (intrt_serviced_i)
    );

    // Clock / watchdog
    initial begin
        pclk_i = 1'b0;
        forever #5 pclk_i = ~pclk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [15:0] act);
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected value queued", tag);
            $fatal(1, "scoreboard underflow");
        end
        check(tag, act, exp_q.pop_front());
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk_i);
        #1;
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [15:0] d,
                             output logic r, output logic e);
        paddr_i   = a;
        pwrite_i  = 1'b1;
        pwdata_i  = d;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        @(posedge pclk_i);
        #1;
        penable_i = 1'b1;
        #1;
        r = pready_o;
        e = perror_o;
        @(posedge pclk_i);
        #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [15:0] d, output logic e);
        paddr_i   = a;
        pwrite_i  = 1'b0;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        #1;
        check("setup_pready", 16'(pready_o), 16'd0);
        @(posedge pclk_i);
        #1;
        penable_i = 1'b1;
        #1;
        check("access_pready", 16'(pready_o), 16'd1);
        d = prdata_o;
        e = perror_o;
        @(posedge pclk_i);
        #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    task automatic pulse_irq5();
        irq_i[5] = 1'b1;
        tick(1);
        irq_i[5] = 1'b0;
        tick(2);
    endtask

    task automatic service(input logic [3:0] idx);
        intrt_to_be_serviced_i = idx;
        intrt_serviced_i       = 1'b1;
        tick(1);
        intrt_serviced_i       = 1'b0;
    endtask

    initial begin
        prst_i = 1'b0;
        irq_i = 16'hFFFF;
        paddr_i = '0;
        pwrite_i = 1'b0;
        pwdata_i = '0;
        psel_i = 1'b0;
        penable_i = 1'b0;
        intrt_to_be_serviced_i = '0;
        intrt_serviced_i = 1'b0;

        // Reset
        tick(2);
        exp_q.push_back(16'h0000);
        sb_check("rst_active", intr_active_o);
        prst_i = 1'b1;
        irq_i  = 16'h0000;
        exp_q.push_back(16'h0000);
        apb_read(A_ENABLE, rd, err);
        sb_check("rst_enable", rd);
        check("rst_rd_err", 16'(err), 16'd0);
        tick(4);

        // Level mode
        apb_write(A_ENABLE, 16'h00FF, rdy, err);
        check("wr_ok_err", 16'(err), 16'd0);
        apb_write(A_MODE, 16'h0000, rdy, err);
        apb_write(A_POLARITY, 16'h0000, rdy, err);
        irq_i = 16'h0208;
        exp_q.push_back(16'h0000);
        tick(2);
        sb_check("lvl_rise_early", intr_active_o);
        exp_q.push_back(16'h0008);
        tick(1);
        sb_check("lvl_rise", intr_active_o);
        irq_i = 16'h0200;
        exp_q.push_back(16'h0008);
        tick(2);
        sb_check("lvl_fall_early", intr_active_o);
        exp_q.push_back(16'h0000);
        tick(1);
        sb_check("lvl_fall", intr_active_o);

        // Edge latch and service
        irq_i = 16'h0000;
        tick(3);
        apb_write(A_MODE, 16'hFFFF, rdy, err);
        apb_write(A_ENABLE, 16'hFFFF, rdy, err);
        exp_q.push_back(16'h0000);
        sb_check("edge_idle", intr_active_o);
        pulse_irq5();
        exp_q.push_back(16'h0020);
        sb_check("edge_latch", intr_active_o);
        tick(5);
        exp_q.push_back(16'h0020);
        sb_check("edge_hold", intr_active_o);
        service(4'd4);
        exp_q.push_back(16'h0020);
        sb_check("svc_other_idx", intr_active_o);
        service(4'd5);
        exp_q.push_back(16'h0000);
        sb_check("svc_clear", intr_active_o);

        // New edge coinciding with a service pulse
        tick(3);
        irq_i[5] = 1'b1;
        tick(1);
        irq_i[5] = 1'b0;
        tick(1);
        service(4'd5);
        exp_q.push_back(16'h0020);
        sb_check("set_wins", intr_active_o);
        exp_q.push_back(16'h0020);
        apb_read(A_PENDING, rd, err);
        sb_check("set_wins_pending", rd);
        service(4'd5);
        exp_q.push_back(16'h0000);
        sb_check("svc_clear2", intr_active_o);

        // Polarity, RAW, W1C
        apb_write(A_POLARITY, 16'h0004, rdy, err);
        exp_q.push_back(16'h0000);
        sb_check("pol_early", intr_active_o);
        tick(1);
        exp_q.push_back(16'h0004);
        sb_check("pol_edge", intr_active_o);
        exp_q.push_back(16'h0000);
        apb_read(A_RAW, rd, err);
        sb_check("raw", rd);
        apb_write(A_PENDING, 16'h0004, rdy, err);
        check("w1c_err", 16'(err), 16'd0);
        exp_q.push_back(16'h0000);
        sb_check("w1c", intr_active_o);

        // APB errors
        apb_write(A_RAW, 16'h0000, rdy, err);
        check("wr4_ready", 16'(rdy), 16'd1);
        check("wr4_err", 16'(err), 16'd1);
        apb_write(3'd6, 16'h0000, rdy, err);
        check("wr6_ready", 16'(rdy), 16'd1);
        check("wr6_err", 16'(err), 16'd1);
        apb_write(3'd5, 16'h0000, rdy, err);
        check("wr5_err", 16'(err), 16'd1);
        exp_q.push_back(16'hFFFF);
        apb_read(A_ENABLE, rd, err);
        sb_check("err_enable_kept", rd);
        exp_q.push_back(16'hFFFF);
        apb_read(A_MODE, rd, err);
        sb_check("err_mode_kept", rd);
        exp_q.push_back(16'h0004);
        apb_read(A_POLARITY, rd, err);
        sb_check("err_pol_kept", rd);
        check("valid_rd_err", 16'(err), 16'd0);
        exp_q.push_back(16'h0000);
        apb_read(3'd7, rd, err);
        sb_check("rd7_data", rd);
        check("rd7_err", 16'(err), 16'd1);

        // Disabling clears pending at the write edge
        pulse_irq5();
        exp_q.push_back(16'h0020);
        sb_check("pre_disable", intr_active_o);
        apb_write(A_ENABLE, 16'h0000, rdy, err);
        exp_q.push_back(16'h0000);
        sb_check("disable_clear", intr_active_o);

        // Reset mid-operation drops latched edges and config
        apb_write(A_ENABLE, 16'hFFFF, rdy, err);
        tick(2);
        pulse_irq5();
        exp_q.push_back(16'h0020);
        sb_check("pre_mid_rst", intr_active_o);
        prst_i = 1'b0;
        tick(1);
        exp_q.push_back(16'h0000);
        sb_check("mid_rst_active", intr_active_o);
        prst_i = 1'b1;
        tick(1);
        exp_q.push_back(16'h0000);
        sb_check("mid_rst_after", intr_active_o);
        exp_q.push_back(16'h0000);
        apb_read(A_MODE, rd, err);
        sb_check("mid_rst_mode", rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
